// File: rtl/uart_pkg.sv
`default_nettype none
// ============================================================================
// Module   : uart_pkg
// Purpose  : Shared types, constants and the round-robin pick helper for the
//            UART transmit scheduler.
// Revision : 1.0 - initial release
// ============================================================================
package uart_pkg;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        LAUNCH    = 2'd1,
        WAIT_DONE = 2'd2,
        GAP       = 2'd3
    } tx_sched_state_e;

    localparam int UART_DATA_BITS = 8;
    localparam int UART_MAX_REQ   = 32;

    // First set bit of valid at or above ptr, wrapping modulo n; -1 if none.
    function automatic int rr_pick(input logic [UART_MAX_REQ-1:0] valid,
                                   input int ptr, input int n);
        int idx;
        rr_pick = -1;
        for (int k = n - 1; k >= 0; k--) begin
            idx = (ptr + k) % n;
            if (valid[idx[4:0]]) rr_pick = idx;
        end
    endfunction

endpackage
`default_nettype wire

// File: rtl/uart_baud_gen.sv
`default_nettype none
// ============================================================================
// Module   : uart_baud_gen
// Purpose  : Free-running divider producing one tick every BAUD_DIV clocks.
// Revision : 1.0 - initial release
// ============================================================================
module uart_baud_gen #(
    parameter int BAUD_DIV = 27
) (
    input  logic clk,
    input  logic rst,
    output logic tick
);

    localparam int CW = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(BAUD_DIV - 1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;
    logic          tick_q;

    always_comb begin
        cnt_d = (cnt_q == LAST) ? '0 : cnt_q + 1'b1;
    end

    // Tick is registered so it tracks the count value it is aligned with.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q  <= '0;
            tick_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            tick_q <= (cnt_d == LAST);
        end
    end

    assign tick = tick_q;

endmodule
`default_nettype wire

// File: rtl/uart_tx_sched.sv
`default_nettype none
// ============================================================================
// Module   : uart_tx_sched
// Purpose  : Round-robin scheduler sharing one UART tx core among NUM_REQ
//            byte producers; also drives the baud tick.
//            Optional inter-frame gap: define UART_TX_SCHED_GAP_EN.
// Revision : 1.0 - initial release
// ============================================================================
module uart_tx_sched
    import uart_pkg::*;
#(
    parameter int NUM_REQ   = 4,
    parameter int DATA_BITS = UART_DATA_BITS,
    parameter int BAUD_DIV  = 27,
    parameter int GAP_TICKS = 16
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [NUM_REQ-1:0]           req_valid,
    input  logic [NUM_REQ*DATA_BITS-1:0] req_data,
    output logic [NUM_REQ-1:0]           req_ready,
    output logic                         tick,
    output logic                         tx_start,
    output logic [DATA_BITS-1:0]         tx_din,
    input  logic                         tx_done,
    output logic                         busy,
    output logic [$clog2(NUM_REQ)-1:0]   grant_id
);

    localparam int GW = $clog2(NUM_REQ);

    tx_sched_state_e      state_q, state_d;
    logic [GW-1:0]        rr_ptr_q, rr_ptr_d;
    logic [GW-1:0]        grant_q, grant_d;
    logic [DATA_BITS-1:0] din_q, din_d;
    int                   pick;
    logic [GW-1:0]        pick_idx;
    logic                 any_valid;

`ifdef UART_TX_SCHED_GAP_EN
    localparam int GCW = (GAP_TICKS > 1) ? $clog2(GAP_TICKS) : 1;
    logic [GCW-1:0] gap_q, gap_d;
`endif

    uart_baud_gen #(.BAUD_DIV(BAUD_DIV)) u_baud (
        .clk  (clk),
        .rst  (rst),
        .tick (tick)
    );

    always_comb begin
        pick = rr_pick(UART_MAX_REQ'(req_valid), int'(rr_ptr_q), NUM_REQ);
    end

    assign any_valid = (pick >= 0);
    assign pick_idx  = GW'(pick);

    always_comb begin
        state_d   = state_q;
        rr_ptr_d  = rr_ptr_q;
        grant_d   = grant_q;
        din_d     = din_q;
        req_ready = '0;
`ifdef UART_TX_SCHED_GAP_EN
        gap_d     = gap_q;
`endif
        case (state_q)
            IDLE: begin
                if (any_valid && !rst) begin
                    req_ready = NUM_REQ'(1) << pick_idx;
                    grant_d   = pick_idx;
                    din_d     = req_data[int'(pick_idx)*DATA_BITS +: DATA_BITS];
                    state_d   = LAUNCH;
                end
            end
            LAUNCH: state_d = WAIT_DONE;
            WAIT_DONE: begin
                if (tx_done) begin
                    rr_ptr_d = (grant_q == GW'(NUM_REQ - 1)) ? '0 : grant_q + 1'b1;
`ifdef UART_TX_SCHED_GAP_EN
                    gap_d    = '0;
                    state_d  = GAP;
`else
                    state_d  = IDLE;
`endif
                end
            end
            default: begin
`ifdef UART_TX_SCHED_GAP_EN
                // Gap length is measured in baud ticks, not clocks.
                if (GAP_TICKS == 0) begin
                    state_d = IDLE;
                end else if (tick) begin
                    if (gap_q == GCW'(GAP_TICKS - 1)) state_d = IDLE;
                    else                              gap_d   = gap_q + 1'b1;
                end
`else
                state_d = IDLE;
`endif
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            rr_ptr_q <= '0;
            grant_q  <= '0;
            din_q    <= '0;
`ifdef UART_TX_SCHED_GAP_EN
            gap_q    <= '0;
`endif
        end else begin
            state_q  <= state_d;
            rr_ptr_q <= rr_ptr_d;
            grant_q  <= grant_d;
            din_q    <= din_d;
`ifdef UART_TX_SCHED_GAP_EN
            gap_q    <= gap_d;
`endif
        end
    end

    assign tx_start = (state_q == LAUNCH) && !rst;
    assign busy     = (state_q != IDLE);
    assign tx_din   = din_q;
    assign grant_id = grant_q;

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_sched.sv
`default_nettype none
// ============================================================================
// Module   : tb_uart_tx_sched
// Purpose  : Directed self-checking bench for uart_tx_sched (BAUD_DIV=4).
// Revision : 1.0 - initial release
// ============================================================================
module tb_uart_tx_sched;

`ifdef UART_TX_SCHED_GAP_EN
    localparam bit GAP_EN = 1'b1;
`else
    localparam bit GAP_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  req_valid;
    logic [31:0] req_data;
    logic [3:0]  req_ready;
    logic        tick;
    logic        tx_start;
    logic [7:0]  tx_din;
    logic        tx_done;
    logic        busy;
    logic [1:0]  grant_id;

    int n_checks = 0;
    int n_pass   = 0;

    uart_tx_sched #(
        .NUM_REQ   (4),
        .DATA_BITS (8),
        .BAUD_DIV  (4),
        .GAP_TICKS (2)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_data  (req_data),
        .req_ready (req_ready),
        .tick      (tick),
        .tx_start  (tx_start),
        .tx_din    (tx_din),
        .tx_done   (tx_done),
        .busy      (busy),
        .grant_id  (grant_id)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] want);
        n_checks++;
        assert (obs === want) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, want);
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // One complete frame: accept, start pulse, wait, done.
    task automatic frame(input int g, input logic [7:0] b);
        int w;
        w = 0;
        #1;
        while (req_ready == 4'b0 && w < 20) begin
            cyc();
            #1;
            w++;
        end
        chk("ready_onehot", 32'(req_ready), 32'(1) << g);
        chk("accept_busy", 32'(busy), 32'(0));
        cyc(); #1;
        chk("start_pulse", 32'(tx_start), 32'(1));
        chk("start_din", 32'(tx_din), 32'(b));
        chk("start_gid", 32'(grant_id), 32'(g));
        chk("launch_ready", 32'(req_ready), 32'(0));
        cyc(); #1;
        chk("start_once", 32'(tx_start), 32'(0));
        chk("wait_busy", 32'(busy), 32'(1));
        cyc();
        tx_done = 1'b1;
        #1;
        chk("done_no_start", 32'(tx_start), 32'(0));
        chk("done_din_held", 32'(tx_din), 32'(b));
        cyc();
        tx_done = 1'b0;
    endtask

    initial begin
        int n_tick;
        int early;
        int w;
        rst       = 1'b1;
        req_valid = 4'b0;
        req_data  = 32'h1312_1110;
        tx_done   = 1'b0;
        cyc(); cyc();

        // Reset values and baud tick phase
        rst = 1'b0;
        #1;
        chk("rst_busy", 32'(busy), 32'(0));
        chk("rst_ready", 32'(req_ready), 32'(0));
        chk("rst_start", 32'(tx_start), 32'(0));
        chk("rst_din", 32'(tx_din), 32'(0));
        chk("rst_gid", 32'(grant_id), 32'(0));
        for (int c = 0; c < 9; c++) begin
            #1;
            chk($sformatf("tick_c%0d", c), 32'(tick), 32'((c % 4) == 3));
            cyc();
        end
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        for (int c = 0; c < 5; c++) begin
            #1;
            chk($sformatf("tick_rst_c%0d", c), 32'(tick), 32'((c % 4) == 3));
            cyc();
        end

        // Single request from requester 2
        req_data  = 32'h13CB_1110;
        req_valid = 4'b0100;
        frame(2, 8'hCB);
        req_valid = 4'b0;
        #1;
        chk("single_idle_busy", 32'(busy), 32'(GAP_EN));
        chk("single_no_ready", 32'(req_ready), 32'(0));
        req_data  = 32'h1312_1110;

        // All valid, starting from pointer 3
        req_valid = 4'b1111;
        frame(3, 8'h13);
        frame(0, 8'h10);
        frame(1, 8'h11);
        frame(2, 8'h12);
        frame(3, 8'h13);
        frame(0, 8'h10);
        req_valid = 4'b0;
        #1;
        chk("all_drop_ready", 32'(req_ready), 32'(0));

        // Stray tx_done in IDLE and LAUNCH; requester 1 withdraws
        if (GAP_EN) begin
            w = 0;
            while (busy && w < 30) begin cyc(); w++; end
        end
        tx_done = 1'b1;
        #1;
        chk("idle_done_busy", 32'(busy), 32'(0));
        cyc();
        tx_done = 1'b0;
        #1;
        chk("idle_done_stay", 32'(busy), 32'(0));
        chk("idle_done_start", 32'(tx_start), 32'(0));
        req_valid = 4'b0001;
        #1;
        chk("ptr1_pick0", 32'(req_ready), 32'(4'b0001));
        cyc();
        req_valid = 4'b1011;
        tx_done   = 1'b1;
        #1;
        chk("launch_start", 32'(tx_start), 32'(1));
        chk("launch_gid", 32'(grant_id), 32'(0));
        cyc();
        tx_done = 1'b0;
        #1;
        chk("launch_done_ignored", 32'(busy), 32'(1));
        cyc(); #1;
        chk("still_waiting", 32'(busy), 32'(1));
        req_valid = 4'b1001;
        tx_done   = 1'b1;
        cyc();
        tx_done = 1'b0;
        frame(3, 8'h13);
        frame(0, 8'h10);
        req_valid = 4'b0;

        // Reset during WAIT_DONE
        if (GAP_EN) begin
            w = 0;
            while (busy && w < 30) begin cyc(); w++; end
        end
        req_valid = 4'b1111;
        #1;
        chk("pre_rst_pick1", 32'(req_ready), 32'(4'b0010));
        cyc(); cyc(); #1;
        chk("pre_rst_wait", 32'(busy), 32'(1));
        rst = 1'b1;
        cyc(); #1;
        chk("rst_mid_busy", 32'(busy), 32'(0));
        chk("rst_mid_start", 32'(tx_start), 32'(0));
        chk("rst_mid_ready", 32'(req_ready), 32'(0));
        chk("rst_mid_gid", 32'(grant_id), 32'(0));
        rst = 1'b0;
        frame(0, 8'h10);

        // Turnaround from done to next accept
        if (GAP_EN) begin
            n_tick = 0;
            early  = 0;
            w      = 0;
            while (n_tick < 2 && w < 40) begin
                #1;
                if (req_ready != 4'b0) early = 1;
                if (tick) n_tick++;
                cyc();
                w++;
            end
            chk("gap_no_early", 32'(early), 32'(0));
            #1;
            chk("gap_then_ready", 32'(req_ready), 32'(4'b0010));
        end else begin
            #1;
            chk("turnaround_ready", 32'(req_ready), 32'(4'b0010));
        end
        frame(1, 8'h11);
        req_valid = 4'b0;
        cyc(); cyc();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
